tail_light_input_conditioner: RTL
=================================

Name: tail_light_input_conditioner

Overview:
- Upstream front-end for the tail-light sequencer. Consumes the raw board inputs SW[2:0] and KEY[1].
- Synchronizes and debounces them, then resolves them into one prioritized mode code.
- Generates the sequencer step tick from the 10 MHz board clock; the tick restarts on every mode change.
- The sequencer consumes only mode, mode_change and step_tick, never raw switches.

Parameters:
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles required before a debounced input changes (20 ms at 10 MHz); legal range >= 2
- TICK_DIV, 2500000, clock cycles per step_tick period (4 Hz); legal range >= 2
- CNT_W, 22, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, TICK_DIV)

Ports:
- ADC_CLK_10  input  1  10 MHz board clock; all flops on rising edge
- KEY0  input  1  asynchronous active-low reset, driven from KEY[0]
- sw_raw  input  3  raw switches; [0]=hazard, [1]=turn enable, [2]=brake
- dir_raw  input  1  raw KEY[1]; 0 = right, 1 = left
- hazard  output  1  debounced sw_raw[0]
- turn_en  output  1  debounced sw_raw[1]
- brake  output  1  debounced sw_raw[2]
- dir_left  output  1  debounced dir_raw
- mode  output  3  registered prioritized mode code
- mode_change  output  1  one-cycle pulse, high on the cycle mode takes a new value
- step_tick  output  1  one-cycle pulse every TICK_DIV cycles while mode != IDLE

Behaviour:
- Reset (KEY0=0, asynchronous): all sync flops, debounced outputs and counters go to 0; mode=IDLE; mode_change=0; step_tick=0. Reset has immediate effect at any point mid-operation. Release is sampled on the next rising edge.
- Synchronizer: each of the 4 inputs passes through 2 flops (s1, s2) before use.
- Debounce, per input, with an independent counter:
  - if s2 == stable, cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1, then stable <= s2 and cnt <= 0;
  - else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES at s2 never reaches the output.
  - Latency from a raw edge to the debounced output is 2 + DEBOUNCE_CYCLES edges.
- Mode resolution uses debounced values, priority high to low:
  - hazard -> HAZARD
  - brake -> BRAKE
  - turn_en & dir_left -> LEFT
  - turn_en & ~dir_left -> RIGHT
  - otherwise IDLE
  - Resolution is combinational; the result is registered into mode, so mode lags the debounced outputs by 1 cycle.
- mode_change: asserted for exactly the cycle in which the mode register holds a value different from its previous value. It is not asserted on reset release while mode stays IDLE.
- Tick counter:
  - In IDLE, or on any cycle where the next mode differs from the current mode, tcnt <= 0 and step_tick <= 0.
  - Otherwise tcnt increments. When tcnt == TICK_DIV-1, step_tick <= 1 and tcnt <= 0.
  - The first step_tick after entering a non-IDLE mode is high exactly TICK_DIV cycles after the cycle mode_change is high.
  - Subsequent ticks are spaced exactly TICK_DIV cycles apart.
- Simultaneous input changes: each input debounces independently. mode may pass through an intermediate value for one or more cycles; each transition produces its own mode_change pulse.
- Direction change while hazard or brake is active: dir_left updates, mode does not change, no mode_change pulse, tick phase undisturbed.
- The step_tick pulse is never wider than 1 cycle and never asserted in IDLE.

Decomposition:
- Package tail_light_pkg:
  - mode encoding: IDLE=3'd0, LEFT=3'd1, RIGHT=3'd2, HAZARD=3'd3, BRAKE=3'd4
  - input bit-index constants: SW_HAZARD=0, SW_TURN=1, SW_BRAKE=2
  - the mode width
- Sub-module debounce_sync: one synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES and CNT_W. Instantiated 4 times.
- Mode register, mode_change and tick counter live in the top of this block.

Test Plan (bench overrides DEBOUNCE_CYCLES=3, TICK_DIV=4, CNT_W=4):
- Reset hold, then release with all inputs 0 for 20 cycles -> all outputs 0, mode=0, no mode_change, no step_tick.
- sw_raw=3'b001 held -> hazard=1 exactly 5 edges after the raw change; mode=3 one edge later with a 1-cycle mode_change; step_tick high 4 cycles after mode_change and every 4 cycles thereafter.
- sw_raw=3'b010, dir_raw=0 -> mode=2 (RIGHT). Then dir_raw=1 -> mode=1 (LEFT) with a mode_change pulse, and the tick counter restarts (next tick 4 cycles after the pulse).
- sw_raw=3'b101 (hazard and brake) -> mode=3. Drop hazard -> mode=4 (BRAKE). Drop brake -> mode=0 with step_tick silent from that cycle on.
- sw_raw[2] pulsed high for 2 cycles only -> brake stays 0, mode stays 0, no mode_change.
- KEY0 asserted mid-HAZARD between ticks -> all outputs 0 immediately (asynchronous). After release with hazard still high -> mode=3 again after 2+3+1 edges.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light input conditioner and the sequencer it feeds.
package tail_light_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        IDLE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        HAZARD = 3'd3,
        BRAKE  = 3'd4
    } mode_e;

    localparam int SW_HAZARD = 0;
    localparam int SW_TURN   = 1;
    localparam int SW_BRAKE  = 2;

    // Hazard outranks brake, which outranks any turn request.
    function automatic mode_e resolve_mode(
        input logic hazard,
        input logic brake,
        input logic turn_en,
        input logic dir_left
    );
        mode_e m;
        if (hazard) begin
            m = HAZARD;
        end else if (brake) begin
            m = BRAKE;
        end else if (turn_en) begin
            m = dir_left ? LEFT : RIGHT;
        end else begin
            m = IDLE;
        end
        return m;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw board input.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 22
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronized input agrees with the stable value restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign deb_o = stable_q;

endmodule

// File: rtl/tail_light_input_conditioner.sv
// Board-input front end: debounces switches/KEY1, resolves the prioritized mode and times step ticks.
module tail_light_input_conditioner
    import tail_light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int TICK_DIV        = 2500000,
    parameter int CNT_W           = 22
) (
    input  logic        ADC_CLK_10,
    input  logic        KEY0,
    input  logic [2:0]  sw_raw,
    input  logic        dir_raw,
    output logic        hazard,
    output logic        turn_en,
    output logic        brake,
    output logic        dir_left,
    output logic [2:0]  mode,
    output logic        mode_change,
    output logic        step_tick
);

    localparam int DIR_BIT = 3;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [3:0]       rawIn;
    logic [3:0]       deb;
    mode_e            mode_q;
    mode_e            mode_d;
    logic             mode_change_q;
    logic             step_tick_q;
    logic             step_tick_d;
    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;

    assign rawIn = {dir_raw, sw_raw};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        debounce_sync #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk_i (ADC_CLK_10),
            .rst_ni(KEY0),
            .raw_i (rawIn[i]),
            .deb_o (deb[i])
        );
    end

    // The tick phase restarts whenever the mode is about to change, so each new mode
    // sees its first tick a full period after its mode_change pulse.
    always_comb begin
        mode_d      = resolve_mode(deb[SW_HAZARD], deb[SW_BRAKE], deb[SW_TURN], deb[DIR_BIT]);
        tcnt_d      = '0;
        step_tick_d = 1'b0;
        if (mode_q != IDLE && mode_d == mode_q) begin
            if (tcnt_q == TICK_LAST) begin
                step_tick_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            mode_q        <= IDLE;
            mode_change_q <= 1'b0;
            step_tick_q   <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            mode_q        <= mode_d;
            mode_change_q <= (mode_d != mode_q);
            step_tick_q   <= step_tick_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign hazard      = deb[SW_HAZARD];
    assign turn_en     = deb[SW_TURN];
    assign brake       = deb[SW_BRAKE];
    assign dir_left    = deb[DIR_BIT];
    assign mode        = mode_q;
    assign mode_change = mode_change_q;
    assign step_tick   = step_tick_q;

endmodule
